// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional `define DIV_FLUSH_EN adds a flush input that aborts any in-flight operation.
`timescale 1ns/1ps
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef DIV_FLUSH_EN
   input  logic             flush,
`endif
   output logic [WIDTH-1:0] out,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             sel_rem_q, sel_rem_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             signed_op, a_neg, b_neg, div_zero, sgn_ovf;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh, diff;
   logic [WIDTH-1:0] quo_sh, rem_nx, quo_fix, rem_fix;

   // Operand conditioning for the accept cycle
   always_comb begin
      signed_op = ~op[0];
      a_neg     = signed_op & rs1[WIDTH-1];
      b_neg     = signed_op & rs2[WIDTH-1];
      a_mag     = a_neg ? -rs1 : rs1;
      b_mag     = b_neg ? -rs2 : rs2;
      div_zero  = (rs2 == '0);
      sgn_ovf   = signed_op && (rs1 == MIN_VAL) && (rs2 == ALL_ONES);
   end

   // One restoring step; the partial remainder never exceeds 2*dvs-1, so WIDTH+1 bits suffice
   always_comb begin
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, dvs_q};
      quo_sh  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      rem_nx  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_fix = neg_quo_q ? -quo_sh : quo_sh;
      rem_fix = neg_rem_q ? -rem_nx : rem_nx;
   end

   always_comb begin
      state_d   = state_q;
      sel_rem_d = sel_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sel_rem_d = op[1];
               if (div_zero) begin
                  res_d   = op[1] ? rs1 : ALL_ONES;
                  state_d = S_DONE;
               end else if (sgn_ovf) begin
                  res_d   = op[1] ? '0 : MIN_VAL;
                  state_d = S_DONE;
               end else begin
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  rem_d     = '0;
                  quo_d     = a_mag;
                  dvs_d     = b_mag;
                  cnt_d     = CW'(WIDTH);
                  state_d   = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = rem_nx;
            quo_d = quo_sh;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               res_d   = sel_rem_q ? rem_fix : quo_fix;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef DIV_FLUSH_EN
      if (flush) begin
         state_d = S_IDLE;
         res_d   = res_q;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sel_rem_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_rem_q <= sel_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         res_q     <= res_d;
         cnt_q     <= cnt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out       = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes model results, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_div_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'd0;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out;
   logic        busy;
`ifdef DIV_FLUSH_EN
   logic        flush = 1'b0;
`endif

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DIV_FLUSH_EN
      .flush(flush),
`endif
      .out(out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] val;
      int          acc;
      int          lat;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t        sb[$];
   int          k = 0;
   int          n_vec = 0;
   int          n_err = 0;
   bit          holding = 0;
   logic [31:0] held;
   int          hold_req = 0;

   always @(posedge clk) k <= k + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference: RISC-V semantics from plain 64-bit arithmetic (truncating division)
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb_, ua, ub, r;
      sa = $signed(a); sb_ = $signed(b);
      ua = a; ub = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         2'd0:    r = sa / sb_;
         2'd1:    r = ua / ub;
         2'd2:    r = sa % sb_;
         default: r = ua % ub;
      endcase
      return r[31:0];
   endfunction

   function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Monitor: compare on first out_valid cycle, check stability while held
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid) begin
            if (!holding) begin
               if (sb.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_result: out=%h with no request outstanding, required none", out);
               end else begin
                  e = sb.pop_front();
                  chk("result", out, e.val);
                  chk("latency", 32'(k - e.acc), 32'(e.lat));
                  $display("txn op=%0d rs1=%h rs2=%h out=%h expected=%h cycles=%0d",
                           e.op, e.a, e.b, out, e.val, k - e.acc);
               end
               held    = out;
               holding = 1;
            end else begin
               chk("hold_stable", out, held);
            end
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            chk("busy_in_done", 32'(busy), 32'd1);
         end
         if (out_valid && hold_req > 0) begin
            out_ready = 1'b0;
            hold_req--;
         end else begin
            out_ready = ($urandom_range(0, 2) != 0);
         end
         if (out_valid && out_ready) holding = 0;
      end else begin
         holding   = 0;
         out_ready = 1'b0;
      end
   end

   // Called at a negedge; returns at a negedge one cycle after acceptance
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      exp_t e;
      op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: in_ready=0 after 200 cycles, required 1");
      end else begin
         e.val = model(o, a, b);
         e.acc = k;
         e.lat = latency(o, a, b);
         e.op = o; e.a = a; e.b = b;
         sb.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb.size() != 0 || holding) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0 || holding) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_out", out, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      hold_req = 5;
      issue(2'd0, 32'd20, 32'hFFFF_FFFD);
      issue(2'd2, 32'd20, 32'hFFFF_FFFD);
      issue(2'd2, 32'hFFFF_FFEC, 32'd3);
      issue(2'd1, 32'hFFFF_FFFF, 32'd2);
      issue(2'd3, 32'hFFFF_FFFF, 32'd2);
      issue(2'd0, 32'd7, 32'd0);
      issue(2'd3, 32'd7, 32'd0);
      issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF);
      drain();

      for (int i = 0; i < 60; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
            default: ;
         endcase
         issue(ro, ra, rb);
      end
      drain();

      // Asynchronous reset in the middle of a computation
      issue(2'd0, 32'd1000, 32'd7);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

`ifdef DIV_FLUSH_EN
      issue(2'd1, 32'd12345, 32'd11);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      sb.delete();
      repeat (40) @(negedge clk);
      issue(2'd3, 32'd100, 32'd9);
      drain();
`endif

      issue(2'd1, 32'd100, 32'd9);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative, multi-cycle divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- It is the sequential counterpart to the single-cycle integer ALU: the decoder issues an operand pair over a valid/ready request port, and the unit returns a result over a valid/ready response port to writeback.
- It stalls the pipeline only through in_ready and out_valid.

Parameters:
- WIDTH, 32, operand and result width in bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- rs1  input  WIDTH  dividend.
- rs2  input  WIDTH  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts result.
- out  output  WIDTH  quotient or remainder, selected by the latched op.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out=0; all internal registers and the counter are cleared.
  - Reset asserted mid-operation aborts the operation and discards any result.
- States: IDLE, CALC, DONE.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE.
- Accept: a request is taken at the edge where in_valid && in_ready. At that edge op, rs1 and rs2 are latched, and inputs are ignored afterwards.
- Signed ops (DIV, REM):
  - Operands are converted to magnitudes.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- Unsigned ops (DIVU, REMU): operands are used as-is.
- Special cases are resolved at accept, and IDLE goes straight to DONE:
  - Divisor 0: quotient = all ones; remainder = rs1 (all four ops).
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- Normal path (IDLE to CALC):
  - Restoring division, one quotient bit per cycle, MSB first.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem using a WIDTH+1-bit subtract.
  - If the result is non-negative, keep it and set quo[0]=1.
  - A counter loaded with WIDTH decrements each CALC cycle. At 0 the next state is DONE and sign correction is applied.
- Latency, with accept at cycle N:
  - Normal path: out_valid rises at cycle N+WIDTH+1 (N+33 for WIDTH=32).
  - Special case: out_valid rises at cycle N+1.
- DONE:
  - out and out_valid are held stable until out_ready=1.
  - On the edge where out_valid && out_ready, the next state is IDLE.
  - No new request is accepted in the same cycle; in_ready first returns at the following cycle.
  - Throughput is one op per WIDTH+2 cycles.
- Simultaneous in_valid with out_ready in DONE: the request is not taken, and the requester must hold it.
- out_ready while not in DONE has no effect.

Optional Feature:
- Macro: DIV_FLUSH_EN.
- With the macro defined:
  - An extra input port `flush` (1 bit) is present.
  - flush=1 at any edge forces state=IDLE and out_valid=0, and the in-flight result is discarded.
  - flush has priority over accept, so a request presented in the same cycle as flush is not taken.
- Without the macro: the port does not exist, and an operation can only be ended by completion or by rst_n.

Test Plan:
- DIV rs1=20, rs2=0xFFFFFFFD (-3) -> out=0xFFFFFFFA (-6). out_valid exactly 33 cycles after accept.
- REM rs1=20, rs2=-3 -> out=2. REM rs1=-20, rs2=3 -> out=0xFFFFFFFE (-2).
- DIVU rs1=0xFFFFFFFF, rs2=2 -> out=0x7FFFFFFF. REMU with the same operands -> out=1.
- Divide by zero, DIV rs1=7, rs2=0 -> out=0xFFFFFFFF, out_valid 1 cycle after accept. REMU with the same operands -> out=7.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> out=0x80000000. REM with the same operands -> out=0. Both 1-cycle.
- Hold out_ready=0 for 5 cycles in DONE -> out, out_valid stable; in_ready=0. Then pulse rst_n=0 at CALC cycle 10 of a new op -> in_ready=1, out_valid=0 immediately. With DIV_FLUSH_EN, flush at CALC cycle 10 -> IDLE on the next edge, no out_valid.
